// File: rtl/spmul_arbiter_pkg.sv
// Shared constants for the SPMUL arbiter: multiplier operand widths, latency
// and the arbiter state encodings.
package spmul_arbiter_pkg;

    localparam int SPMUL_SIG_W   = 16;
    localparam int SPMUL_COEF_W  = 10;
    localparam int SPMUL_LATENCY = 12;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_ACK   = 2'd3;

    typedef logic [SPMUL_SIG_W-1:0]  spmul_sig_t;
    typedef logic [SPMUL_COEF_W-1:0] spmul_coef_t;

endpackage

// File: rtl/spmul_arbiter_if.sv
// Bundle of requester-side and SPMUL-side signals around the arbiter.
// The arbiter takes the slave modport; the environment drives the master side.
interface spmul_arbiter_if #(parameter int NREQ = 4);
    import spmul_arbiter_pkg::*;

    logic [NREQ-1:0]              req;
    logic [SPMUL_SIG_W*NREQ-1:0]  sig_in;
    logic [SPMUL_COEF_W*NREQ-1:0] coef_in;
    logic [NREQ-1:0]              ack;
    spmul_sig_t                   result_out;
    logic                         busy;
    logic                         mul_start;
    spmul_sig_t                   mul_sig;
    spmul_coef_t                  mul_coef;
    spmul_sig_t                   mul_result;
    logic                         mul_done;

    modport slave (
        input  req, sig_in, coef_in, mul_result, mul_done,
        output ack, result_out, busy, mul_start, mul_sig, mul_coef
    );

    modport master (
        output req, sig_in, coef_in, mul_result, mul_done,
        input  ack, result_out, busy, mul_start, mul_sig, mul_coef
    );

endinterface

// File: rtl/spmul_arbiter_rr_select.sv
// Combinational round-robin priority encoder: first asserted request found
// searching upward from last_grant+1 with wrap-around.
module spmul_arbiter_rr_select #(
    parameter int NREQ = 4,
    parameter int IDXW = 2
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDXW-1:0] last_grant_i,
    output logic [IDXW-1:0] winner_o,
    output logic            valid_o
);

    // Walk from the lowest priority to the highest so the last hit wins.
    always_comb begin
        logic [IDXW-1:0] idx_w;
        winner_o = '0;
        valid_o  = 1'b0;
        idx_w    = '0;
        for (int k = NREQ; k >= 1; k--) begin
            idx_w = IDXW'((int'(last_grant_i) + k) % NREQ);
            if (req_i[idx_w]) begin
                winner_o = idx_w;
                valid_o  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/spmul_arbiter.sv
// Round-robin sharing of one 16x10 serial/parallel multiplier between NREQ
// requesters: grant, issue, wait for done, return the product with a 1-cycle ack.
module spmul_arbiter
    import spmul_arbiter_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDXW = 2
) (
    input  logic          clk,
    input  logic          rst_an,
    spmul_arbiter_if.slave bus
);

    logic [1:0]      state_q, state_d;
    logic [IDXW-1:0] owner_q, owner_d;
    logic [IDXW-1:0] last_q, last_d;
    spmul_sig_t      sig_q, sig_d;
    spmul_coef_t     coef_q, coef_d;
    spmul_sig_t      result_q, result_d;
    logic [NREQ-1:0] ack_q, ack_d;

    logic [IDXW-1:0] sel_winner;
    logic            sel_valid;

    spmul_arbiter_rr_select #(
        .NREQ (NREQ),
        .IDXW (IDXW)
    ) u_rr_select (
        .req_i        (bus.req),
        .last_grant_i (last_q),
        .winner_o     (sel_winner),
        .valid_o      (sel_valid)
    );

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        last_d   = last_q;
        sig_d    = sig_q;
        coef_d   = coef_q;
        result_d = result_q;
        ack_d    = '0;
        case (state_q)
            ST_IDLE: begin
                if (sel_valid && bus.mul_done) begin
                    owner_d = sel_winner;
                    last_d  = sel_winner;
                    sig_d   = bus.sig_in[SPMUL_SIG_W*int'(sel_winner) +: SPMUL_SIG_W];
                    coef_d  = bus.coef_in[SPMUL_COEF_W*int'(sel_winner) +: SPMUL_COEF_W];
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT: begin
                // done is forced low by SPMUL while start is high, so it is fresh here
                if (bus.mul_done) begin
                    result_d       = bus.mul_result;
                    ack_d[owner_q] = 1'b1;
                    state_d        = ST_ACK;
                end
            end
            ST_ACK:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_an) begin
        if (!rst_an) begin
            state_q  <= ST_IDLE;
            owner_q  <= '0;
            last_q   <= IDXW'(NREQ - 1);
            sig_q    <= '0;
            coef_q   <= '0;
            result_q <= '0;
            ack_q    <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            sig_q    <= sig_d;
            coef_q   <= coef_d;
            result_q <= result_d;
            ack_q    <= ack_d;
        end
    end

    assign bus.ack        = ack_q;
    assign bus.result_out = result_q;
    assign bus.busy       = (state_q != ST_IDLE);
    assign bus.mul_start  = (state_q == ST_ISSUE);
    assign bus.mul_sig    = sig_q;
    assign bus.mul_coef   = coef_q;

endmodule

// File: tb/tb_spmul_arbiter.sv
// Bench for spmul_arbiter with a behavioural SPMUL and a transaction-level
// reference model of the round-robin schedule.
module tb_spmul_arbiter;
    import spmul_arbiter_pkg::*;

    localparam int NREQ = 4;
    localparam int IDXW = 2;

    logic clk = 1'b0;
    logic rst_an = 1'b0;
    always #5 clk = ~clk;

    spmul_arbiter_if #(.NREQ(NREQ)) bus ();

    spmul_arbiter #(
        .NREQ (NREQ),
        .IDXW (IDXW)
    ) dut (
        .clk    (clk),
        .rst_an (rst_an),
        .bus    (bus)
    );

    logic [NREQ-1:0]    req_r  = '0;
    logic [16*NREQ-1:0] sig_r  = '0;
    logic [10*NREQ-1:0] coef_r = '0;
    assign bus.req     = req_r;
    assign bus.sig_in  = sig_r;
    assign bus.coef_in = coef_r;

    // Q15 signal times sign-magnitude Q9 coefficient.
    function automatic logic [15:0] ref_product(input logic [15:0] s, input logic [9:0] c);
        int sv;
        int mv;
        int p;
        sv = int'($signed(s));
        mv = int'({23'd0, c[8:0]});
        p  = (sv * mv) >>> 9;
        if (c[9]) p = -p;
        return 16'(p);
    endfunction

    // Behavioural SPMUL: done drops with start, returns SPMUL_LATENCY cycles later.
    logic [3:0]  mcnt_q;
    logic [15:0] mres_q;
    logic [15:0] mpend_q;
    always @(posedge clk or negedge rst_an) begin
        if (!rst_an) begin
            mcnt_q  <= 4'd0;
            mres_q  <= 16'd0;
            mpend_q <= 16'd0;
        end else if (bus.mul_start) begin
            mcnt_q  <= 4'(SPMUL_LATENCY - 2);
            mpend_q <= ref_product(bus.mul_sig, bus.mul_coef);
        end else if (mcnt_q != 4'd0) begin
            mcnt_q <= mcnt_q - 4'd1;
            if (mcnt_q == 4'd1) mres_q <= mpend_q;
        end
    end
    assign bus.mul_done   = !bus.mul_start && (mcnt_q == 4'd0);
    assign bus.mul_result = mres_q;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int busy_cnt = 0;
    logic [NREQ-1:0] drop_mask = '1;

    // Reference schedule: one grant at a time, ack 13 cycles after the grant,
    // arbiter free again 14 cycles after the grant.
    bit          m_active = 1'b0;
    int          m_g      = 0;
    int          m_owner  = 0;
    int          m_last   = NREQ - 1;
    logic [15:0] m_sig_exp, m_prod;
    logic [9:0]  m_coef_exp;
    logic [15:0] m_result = 16'd0;

    int          ack_idx_q[$];
    int          ack_cyc_q[$];
    logic [15:0] ack_res_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, obs, exp, cyc);
    endtask

    task automatic tick();
        logic [NREQ-1:0] ack_now;
        int  idx;
        bit  found;
        bit  ack_exp;
        @(negedge clk);
        ack_exp = m_active && (cyc == m_g + 13);
        if (ack_exp) m_result = m_prod;
        check("ack", 32'(bus.ack), ack_exp ? (32'd1 << m_owner) : 32'd0);
        check("busy", 32'(bus.busy), 32'(m_active && cyc >= m_g + 1 && cyc <= m_g + 13));
        check("mul_start", 32'(bus.mul_start), 32'(m_active && cyc == m_g + 1));
        check("result_out", 32'(bus.result_out), 32'(m_result));
        if (m_active && cyc == m_g + 1) begin
            check("mul_sig", 32'(bus.mul_sig), 32'(m_sig_exp));
            check("mul_coef", 32'(bus.mul_coef), 32'(m_coef_exp));
        end
        if (bus.busy) busy_cnt++;
        ack_now = bus.ack;
        if (ack_now != '0) begin
            for (int i = 0; i < NREQ; i++) if (ack_now[i]) ack_idx_q.push_back(i);
            ack_cyc_q.push_back(cyc);
            ack_res_q.push_back(bus.result_out);
            $display("cycle %0d: ack=%b result=%h", cyc, ack_now, bus.result_out);
        end
        if ((!m_active || cyc >= m_g + 14) && req_r != '0) begin
            found = 1'b0;
            for (int k = 1; k <= NREQ; k++) begin
                idx = (m_last + k) % NREQ;
                if (!found && req_r[idx]) begin
                    found   = 1'b1;
                    m_owner = idx;
                end
            end
            m_last     = m_owner;
            m_g        = cyc;
            m_active   = 1'b1;
            m_sig_exp  = sig_r[16*m_owner +: 16];
            m_coef_exp = coef_r[10*m_owner +: 10];
            m_prod     = ref_product(m_sig_exp, m_coef_exp);
        end
        @(posedge clk);
        #1;
        cyc++;
        req_r = req_r & ~(ack_now & drop_mask);
    endtask

    task automatic set_req(input int i, input logic [15:0] s, input logic [9:0] c);
        sig_r[16*i +: 16]  = s;
        coef_r[10*i +: 10] = c;
        req_r[i]           = 1'b1;
    endtask

    task automatic clear_log();
        ack_idx_q.delete();
        ack_cyc_q.delete();
        ack_res_q.delete();
    endtask

    task automatic run_acks(input int n, input int budget);
        int t;
        t = 0;
        while (ack_idx_q.size() < n && t < budget) begin
            tick();
            t++;
        end
        check("ack_count", 32'(ack_idx_q.size()), 32'(n));
    endtask

    // Called just after a clock edge; asserts reset mid-cycle.
    task automatic apply_reset();
        #2 rst_an = 1'b0;
        #1;
        check("rst_ack", 32'(bus.ack), 32'd0);
        check("rst_result", 32'(bus.result_out), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_start", 32'(bus.mul_start), 32'd0);
        req_r    = '0;
        m_active = 1'b0;
        m_last   = NREQ - 1;
        m_result = 16'd0;
        @(negedge clk);
        rst_an = 1'b1;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        int  c0;
        bit  flag;
        int  t;
        int  exp_order[$];

        #3;
        check("init_ack", 32'(bus.ack), 32'd0);
        check("init_result", 32'(bus.result_out), 32'd0);
        check("init_busy", 32'(bus.busy), 32'd0);
        check("init_start", 32'(bus.mul_start), 32'd0);
        check("init_mul_sig", 32'(bus.mul_sig), 32'd0);
        check("init_mul_coef", 32'(bus.mul_coef), 32'd0);
        @(negedge clk);
        rst_an = 1'b1;
        @(posedge clk);
        #1;

        // Single uncontended request.
        clear_log();
        busy_cnt = 0;
        c0 = cyc;
        set_req(0, 16'h4000, 10'h100);
        run_acks(1, 40);
        repeat (3) tick();
        if (ack_idx_q.size() > 0) begin
            check("t1_idx", 32'(ack_idx_q[0]), 32'd0);
            check("t1_latency", 32'(ack_cyc_q[0] - c0), 32'd13);
            check("t1_result", 32'(ack_res_q[0]), 32'h2000);
        end
        check("t1_busy_cycles", 32'(busy_cnt), 32'd13);

        // Negative sign-magnitude coefficient.
        clear_log();
        set_req(2, 16'h4000, 10'h300);
        run_acks(1, 40);
        if (ack_idx_q.size() > 0) begin
            check("t2_idx", 32'(ack_idx_q[0]), 32'd2);
            check("t2_result", 32'(ack_res_q[0]), 32'hE000);
        end

        // All four from reset, req0 re-asserted right after its ack.
        apply_reset();
        clear_log();
        for (int i = 0; i < NREQ; i++) set_req(i, 16'($urandom), 10'($urandom));
        flag = 1'b0;
        t = 0;
        while (ack_idx_q.size() < 5 && t < 120) begin
            tick();
            t++;
            if (!flag && ack_idx_q.size() == 1) begin
                req_r[0] = 1'b1;
                flag = 1'b1;
            end
        end
        check("t3_ack_count", 32'(ack_idx_q.size()), 32'd5);
        exp_order = '{0, 1, 2, 3, 0};
        for (int j = 0; j < ack_idx_q.size() && j < 5; j++) begin
            check("t3_order", 32'(ack_idx_q[j]), 32'(exp_order[j]));
            if (j > 0) check("t3_spacing", 32'(ack_cyc_q[j] - ack_cyc_q[j-1]), 32'd14);
            if (j < 4) check("t3_product", 32'(ack_res_q[j]),
                             32'(ref_product(sig_r[16*j +: 16], coef_r[10*j +: 10])));
        end

        // Fairness: req1 held, req3 raised during req1's WAIT.
        clear_log();
        drop_mask = 4'b1101;
        set_req(1, 16'h7FFF, 10'h1FF);
        sig_r[16*3 +: 16]  = 16'h8001;
        coef_r[10*3 +: 10] = 10'h080;
        flag = 1'b0;
        t = 0;
        while (ack_idx_q.size() < 3 && t < 100) begin
            tick();
            t++;
            if (!flag && m_active && m_owner == 1 && cyc == m_g + 5) begin
                req_r[3] = 1'b1;
                flag = 1'b1;
            end
        end
        req_r[1]  = 1'b0;
        drop_mask = '1;
        check("t4_ack_count", 32'(ack_idx_q.size()), 32'd3);
        exp_order = '{1, 3, 1};
        for (int j = 0; j < ack_idx_q.size() && j < 3; j++)
            check("t4_order", 32'(ack_idx_q[j]), 32'(exp_order[j]));

        // Withdrawal before grant, and operand change after grant.
        clear_log();
        set_req(0, 16'h1234, 10'h0AB);
        tick();
        tick();
        set_req(2, 16'h5555, 10'h155);
        tick();
        tick();
        req_r[2] = 1'b0;
        set_req(3, 16'h3000, 10'h3C0);
        flag = 1'b0;
        t = 0;
        while (ack_idx_q.size() < 2 && t < 80) begin
            tick();
            t++;
            if (!flag && m_active && m_owner == 3 && cyc > m_g) begin
                sig_r[16*3 +: 16] = 16'h7FFF;
                flag = 1'b1;
            end
        end
        repeat (20) tick();
        check("t5_ack_count", 32'(ack_idx_q.size()), 32'd2);
        exp_order = '{0, 3};
        for (int j = 0; j < ack_idx_q.size() && j < 2; j++)
            check("t5_order", 32'(ack_idx_q[j]), 32'(exp_order[j]));
        if (ack_res_q.size() > 1)
            check("t5_grant_operand", 32'(ack_res_q[1]), 32'(ref_product(16'h3000, 10'h3C0)));

        // Reset during WAIT, then a fresh request.
        set_req(1, 16'h2000, 10'h1FF);
        repeat (5) tick();
        apply_reset();
        clear_log();
        c0 = cyc;
        set_req(0, 16'h4000, 10'h100);
        run_acks(1, 40);
        if (ack_idx_q.size() > 0) begin
            check("t6_latency", 32'(ack_cyc_q[0] - c0), 32'd13);
            check("t6_result", 32'(ack_res_q[0]), 32'h2000);
        end
        repeat (2) tick();

        // Randomized traffic against the reference schedule.
        for (int n = 0; n < 700; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!req_r[i] && $urandom_range(7) == 0)
                    set_req(i, 16'($urandom), 10'($urandom));
                else if (req_r[i] && $urandom_range(40) == 0)
                    req_r[i] = 1'b0;
            end
            if ($urandom_range(9) == 0)
                sig_r[16*$urandom_range(NREQ-1) +: 16] = 16'($urandom);
            tick();
        end
        req_r = '0;
        repeat (20) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
